// File: rtl/traffic_sensor_ctrl.sv
// Road-side sensor companion for the two-street traffic-light controller:
// debounced loop detectors feed per-street vehicle queues, drained while green.
module traffic_sensor_ctrl #(
    parameter int DEB_CYCLES    = 4,
    parameter int DEPART_CYCLES = 8,
    parameter int QW            = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          car_a_raw,
    input  logic          car_b_raw,
    input  logic [2:0]    LA,
    input  logic [2:0]    LB,
    output logic          Ta,
    output logic          Tb,
    output logic [QW-1:0] qa,
    output logic [QW-1:0] qb,
    output logic          q_ovf,
    output logic          lamp_fault
);

    localparam int DCW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int TW  = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;

    localparam logic [DCW-1:0] DEB_LAST = DCW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0]  DEP_LAST = TW'(DEPART_CYCLES - 1);
    localparam logic [QW-1:0]  Q_MAX    = {QW{1'b1}};

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    // Index 0 is street A, index 1 is street B throughout.
    logic [1:0]               sync1_q, sync1_d;
    logic [1:0]               sync2_q, sync2_d;
    logic [1:0]               deb_q, deb_d;
    logic [1:0][DCW-1:0]      deb_cnt_q, deb_cnt_d;
    logic [1:0][TW-1:0]       dep_tmr_q, dep_tmr_d;
    logic [1:0][QW-1:0]       q_q, q_d;
    logic                     q_ovf_q, q_ovf_d;
    logic                     lamp_fault_q, lamp_fault_d;
    logic [2:0]               prev_la_q, prev_la_d;
    logic [2:0]               prev_lb_q, prev_lb_d;

    logic [1:0]               raw_w;
    logic [1:0][2:0]          lamp_w;
    logic [1:0]               arrival;
    logic [1:0]               departure;
    logic                     ovf_set;
    logic                     lamp_bad;

    function automatic logic legal_code(input logic [2:0] c);
        return (c == RED) || (c == YEL) || (c == GRN);
    endfunction

    // Holding a code is always allowed; only the controller's forward cycle may change it.
    function automatic logic legal_step(input logic [2:0] prev, input logic [2:0] cur);
        return (cur == prev) ||
               ((prev == GRN) && (cur == YEL)) ||
               ((prev == YEL) && (cur == RED)) ||
               ((prev == RED) && (cur == GRN));
    endfunction

    assign raw_w     = {car_b_raw, car_a_raw};
    assign lamp_w[0] = LA;
    assign lamp_w[1] = LB;

    always_comb begin
        sync1_d   = raw_w;
        sync2_d   = sync1_q;
        deb_d     = deb_q;
        deb_cnt_d = '0;
        dep_tmr_d = '0;
        q_d       = q_q;
        arrival   = '0;
        departure = '0;
        ovf_set   = 1'b0;

        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DCW'(1);
                end
            end
            arrival[i] = deb_d[i] & ~deb_q[i];

            if ((lamp_w[i] == GRN) && (q_q[i] != '0)) begin
                if (dep_tmr_q[i] == DEP_LAST) begin
                    departure[i] = 1'b1;
                end else begin
                    dep_tmr_d[i] = dep_tmr_q[i] + TW'(1);
                end
            end

            // A simultaneous arrival and departure cancel, even at saturation.
            if (arrival[i] && !departure[i]) begin
                if (q_q[i] == Q_MAX) begin
                    ovf_set = 1'b1;
                end else begin
                    q_d[i] = q_q[i] + QW'(1);
                end
            end else if (departure[i] && !arrival[i]) begin
                q_d[i] = q_q[i] - QW'(1);
            end
        end

        q_ovf_d = q_ovf_q | ovf_set;
    end

    always_comb begin
        lamp_bad = ~legal_code(LA) | ~legal_code(LB) |
                   ((LA != RED) && (LB != RED)) |
                   ~legal_step(prev_la_q, LA) | ~legal_step(prev_lb_q, LB);
        lamp_fault_d = lamp_fault_q | lamp_bad;
        prev_la_d    = LA;
        prev_lb_d    = LB;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            deb_q        <= '0;
            deb_cnt_q    <= '0;
            dep_tmr_q    <= '0;
            q_q          <= '0;
            q_ovf_q      <= 1'b0;
            lamp_fault_q <= 1'b0;
            prev_la_q    <= GRN;
            prev_lb_q    <= RED;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            deb_q        <= deb_d;
            deb_cnt_q    <= deb_cnt_d;
            dep_tmr_q    <= dep_tmr_d;
            q_q          <= q_d;
            q_ovf_q      <= q_ovf_d;
            lamp_fault_q <= lamp_fault_d;
            prev_la_q    <= prev_la_d;
            prev_lb_q    <= prev_lb_d;
        end
    end

    assign qa         = q_q[0];
    assign qb         = q_q[1];
    assign Ta         = |q_q[0];
    assign Tb         = |q_q[1];
    assign q_ovf      = q_ovf_q;
    assign lamp_fault = lamp_fault_q;

endmodule

// File: tb/tb_traffic_sensor_ctrl.sv
// Directed bench for traffic_sensor_ctrl: arrivals, glitch rejection, draining,
// saturation, lamp monitoring and mid-operation reset.
module tb_traffic_sensor_ctrl;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    logic       clk;
    logic       reset_n;
    logic       car_a_raw;
    logic       car_b_raw;
    logic [2:0] LA;
    logic [2:0] LB;
    logic       Ta;
    logic       Tb;
    logic [3:0] qa;
    logic [3:0] qb;
    logic       q_ovf;
    logic       lamp_fault;

    int checks = 0;
    int errors = 0;

    traffic_sensor_ctrl #(
        .DEB_CYCLES   (4),
        .DEPART_CYCLES(8),
        .QW           (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .car_a_raw (car_a_raw),
        .car_b_raw (car_b_raw),
        .LA        (LA),
        .LB        (LB),
        .Ta        (Ta),
        .Tb        (Tb),
        .qa        (qa),
        .qb        (qb),
        .q_ovf     (q_ovf),
        .lamp_fault(lamp_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        car_a_raw = 1'b0;
        car_b_raw = 1'b0;
        LA        = GRN;
        LB        = RED;
        tick(2);
        reset_n   = 1'b1;
    endtask

    task automatic a_to_red();
        LA = YEL;
        tick(1);
        LA = RED;
        tick(1);
    endtask

    task automatic pulse_a(input int hi, input int lo);
        car_a_raw = 1'b1;
        tick(hi);
        car_a_raw = 1'b0;
        tick(lo);
    endtask

    task automatic pulse_b(input int hi, input int lo);
        car_b_raw = 1'b1;
        tick(hi);
        car_b_raw = 1'b0;
        tick(lo);
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        car_a_raw = 1'b0;
        car_b_raw = 1'b0;
        LA        = GRN;
        LB        = RED;
        #1;
        checks++;
        if ({Ta, Tb, qa, qb, q_ovf, lamp_fault} !== 12'd0) begin
            errors++;
            $display("FAIL reset_async: got %b expected 0", {Ta, Tb, qa, qb, q_ovf, lamp_fault});
        end
        tick(2);
        reset_n = 1'b1;
        tick(3);
        checks++;
        if ({Ta, Tb, qa, qb, q_ovf, lamp_fault} !== 12'd0) begin
            errors++;
            $display("FAIL reset_idle: got %b expected 0", {Ta, Tb, qa, qb, q_ovf, lamp_fault});
        end
        $display("test_reset done");
    endtask

    task automatic test_arrival();
        do_reset();
        a_to_red();
        car_a_raw = 1'b1;
        tick(5);
        checks++;
        if (qa !== 4'd0) begin
            errors++;
            $display("FAIL arrival_edge5: qa got %0d expected 0", qa);
        end
        tick(1);
        checks++;
        if (qa !== 4'd1 || Ta !== 1'b1) begin
            errors++;
            $display("FAIL arrival_edge6: qa=%0d Ta=%b expected qa=1 Ta=1", qa, Ta);
        end
        tick(4);
        car_a_raw = 1'b0;
        tick(10);
        checks++;
        if (qa !== 4'd1 || lamp_fault !== 1'b0) begin
            errors++;
            $display("FAIL arrival_release: qa=%0d fault=%b expected qa=1 fault=0", qa, lamp_fault);
        end
        $display("test_arrival done: qa=%0d", qa);
    endtask

    task automatic test_glitch();
        do_reset();
        a_to_red();
        car_b_raw = 1'b1;
        tick(3);
        car_b_raw = 1'b0;
        tick(10);
        checks++;
        if (qb !== 4'd0 || Tb !== 1'b0) begin
            errors++;
            $display("FAIL glitch_reject: qb=%0d Tb=%b expected qb=0 Tb=0", qb, Tb);
        end
        pulse_b(8, 8);
        checks++;
        if (qb !== 4'd1 || Tb !== 1'b1 || qa !== 4'd0) begin
            errors++;
            $display("FAIL b_arrival: qb=%0d Tb=%b qa=%0d expected qb=1 Tb=1 qa=0", qb, Tb, qa);
        end
        $display("test_glitch done: qb=%0d", qb);
    endtask

    task automatic test_drain();
        do_reset();
        a_to_red();
        repeat (3) pulse_a(8, 8);
        checks++;
        if (qa !== 4'd3) begin
            errors++;
            $display("FAIL drain_load: qa got %0d expected 3", qa);
        end
        LA = GRN;
        tick(7);
        checks++;
        if (qa !== 4'd3) begin
            errors++;
            $display("FAIL drain_edge7: qa got %0d expected 3", qa);
        end
        tick(1);
        checks++;
        if (qa !== 4'd2) begin
            errors++;
            $display("FAIL drain_edge8: qa got %0d expected 2", qa);
        end
        tick(7);
        checks++;
        if (qa !== 4'd2) begin
            errors++;
            $display("FAIL drain_edge15: qa got %0d expected 2", qa);
        end
        tick(1);
        checks++;
        if (qa !== 4'd1) begin
            errors++;
            $display("FAIL drain_edge16: qa got %0d expected 1", qa);
        end
        tick(7);
        checks++;
        if (qa !== 4'd1 || Ta !== 1'b1) begin
            errors++;
            $display("FAIL drain_edge23: qa=%0d Ta=%b expected qa=1 Ta=1", qa, Ta);
        end
        tick(1);
        checks++;
        if (qa !== 4'd0 || Ta !== 1'b0) begin
            errors++;
            $display("FAIL drain_edge24: qa=%0d Ta=%b expected qa=0 Ta=0", qa, Ta);
        end
        tick(10);
        checks++;
        if (qa !== 4'd0 || lamp_fault !== 1'b0) begin
            errors++;
            $display("FAIL drain_idle: qa=%0d fault=%b expected qa=0 fault=0", qa, lamp_fault);
        end
        $display("test_drain done: qa=%0d", qa);
    endtask

    task automatic test_saturate();
        do_reset();
        a_to_red();
        repeat (15) pulse_a(8, 8);
        checks++;
        if (qa !== 4'd15 || q_ovf !== 1'b0) begin
            errors++;
            $display("FAIL sat_load: qa=%0d ovf=%b expected qa=15 ovf=0", qa, q_ovf);
        end
        // Green from edge 1 departs at edge 8; raw raised before edge 3 arrives at edge 8.
        LA = GRN;
        tick(2);
        car_a_raw = 1'b1;
        tick(5);
        checks++;
        if (qa !== 4'd15) begin
            errors++;
            $display("FAIL sat_edge7: qa got %0d expected 15", qa);
        end
        tick(1);
        checks++;
        if (qa !== 4'd15 || q_ovf !== 1'b0) begin
            errors++;
            $display("FAIL sat_coincide: qa=%0d ovf=%b expected qa=15 ovf=0", qa, q_ovf);
        end
        LA        = YEL;
        car_a_raw = 1'b0;
        tick(1);
        LA = RED;
        tick(10);
        checks++;
        if (qa !== 4'd15 || q_ovf !== 1'b0) begin
            errors++;
            $display("FAIL sat_hold: qa=%0d ovf=%b expected qa=15 ovf=0", qa, q_ovf);
        end
        pulse_a(8, 8);
        checks++;
        if (qa !== 4'd15 || q_ovf !== 1'b1 || lamp_fault !== 1'b0) begin
            errors++;
            $display("FAIL sat_overflow: qa=%0d ovf=%b fault=%b expected qa=15 ovf=1 fault=0",
                     qa, q_ovf, lamp_fault);
        end
        $display("test_saturate done: qa=%0d ovf=%b", qa, q_ovf);
    endtask

    task automatic test_lamp();
        do_reset();
        LA = YEL; tick(1);
        LA = RED; tick(1);
        LB = GRN; tick(1);
        LB = YEL; tick(1);
        LB = RED; tick(1);
        LA = GRN; tick(1);
        checks++;
        if (lamp_fault !== 1'b0) begin
            errors++;
            $display("FAIL lamp_legal_cycle: got %b expected 0", lamp_fault);
        end
        LB = GRN;
        #1;
        checks++;
        if (lamp_fault !== 1'b0) begin
            errors++;
            $display("FAIL lamp_conflict_pre: got %b expected 0", lamp_fault);
        end
        tick(1);
        LB = RED;
        checks++;
        if (lamp_fault !== 1'b1) begin
            errors++;
            $display("FAIL lamp_conflict: got %b expected 1", lamp_fault);
        end
        tick(5);
        checks++;
        if (lamp_fault !== 1'b1) begin
            errors++;
            $display("FAIL lamp_sticky: got %b expected 1", lamp_fault);
        end
        do_reset();
        checks++;
        if (lamp_fault !== 1'b0) begin
            errors++;
            $display("FAIL lamp_reset_clear: got %b expected 0", lamp_fault);
        end
        LA = RED;
        tick(1);
        checks++;
        if (lamp_fault !== 1'b1) begin
            errors++;
            $display("FAIL lamp_bad_step: got %b expected 1", lamp_fault);
        end
        do_reset();
        LA = 3'b011;
        tick(1);
        checks++;
        if (lamp_fault !== 1'b1) begin
            errors++;
            $display("FAIL lamp_bad_code: got %b expected 1", lamp_fault);
        end
        $display("test_lamp done: fault=%b", lamp_fault);
    endtask

    task automatic test_reset_mid();
        do_reset();
        a_to_red();
        repeat (2) pulse_a(8, 8);
        LA = GRN;
        tick(5);
        checks++;
        if (qa !== 4'd2) begin
            errors++;
            $display("FAIL mid_preload: qa got %0d expected 2", qa);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({Ta, Tb, qa, qb, q_ovf, lamp_fault} !== 12'd0) begin
            errors++;
            $display("FAIL mid_async_clear: got %b expected 0", {Ta, Tb, qa, qb, q_ovf, lamp_fault});
        end
        tick(1);
        reset_n   = 1'b1;
        car_a_raw = 1'b1;
        tick(5);
        checks++;
        if (qa !== 4'd0) begin
            errors++;
            $display("FAIL mid_edge5: qa got %0d expected 0", qa);
        end
        tick(1);
        checks++;
        if (qa !== 4'd1) begin
            errors++;
            $display("FAIL mid_arrival: qa got %0d expected 1", qa);
        end
        tick(7);
        checks++;
        if (qa !== 4'd1) begin
            errors++;
            $display("FAIL mid_edge13: qa got %0d expected 1", qa);
        end
        tick(1);
        checks++;
        if (qa !== 4'd0 || Ta !== 1'b0) begin
            errors++;
            $display("FAIL mid_depart: qa=%0d Ta=%b expected qa=0 Ta=0", qa, Ta);
        end
        car_a_raw = 1'b0;
        tick(8);
        $display("test_reset_mid done: qa=%0d", qa);
    endtask

    initial begin
        test_reset();
        test_arrival();
        test_glitch();
        test_drain();
        test_saturate();
        test_lamp();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
